catraca_arbitro: RTL and testbench

Turnstile controller that shares one bus turnstile between `NPASS` card holders. It keeps a saturating balance per card, arbitrates simultaneous card swipes, debits the granted card and holds the turnstile released for a fixed number of cycles. It sits between the switch-level inputs (swipes, top-ups) and the turnstile LED/display outputs in the board top level.

---
 rtl/catraca_arbitro.sv | 196 +++++++++++++++++++
 tb/tb_catraca_arbitro.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/catraca_arbitro.sv
// rtl/catraca_arbitro.sv - shared bus turnstile controller with per-card saturating balances
//
// Purpose: arbitrates card swipes from NPASS passengers, debits the granted
// card and holds the turnstile released for T_LIBERA cycles. A swipe with a
// zero balance is refused with a one-cycle negado pulse. A held swipe is
// served once; a new service needs release and re-swipe.
//
// Configuration macro: CATRACA_RR_EN
//   defined   - simultaneous requests resolved round-robin from prio
//   undefined - simultaneous requests are ignored until only one remains
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   passe    in   [NPASS]   card swipe levels, bit i = passenger i
//   carrega  in   [2*NPASS] top-up amount per card, bits [2i+1:2i]
//   catraca  out  turnstile released
//   conta    out  [3]       balance of card atual
//   atual    out  [AW]      last granted or denied passenger
//   negado   out  one-cycle pulse on a refused swipe

module catraca_arbitro #(
    parameter int NPASS     = 2,
    parameter int SALDO_MAX = 5,
    parameter int T_LIBERA  = 3
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic [NPASS-1:0]                            passe,
    input  logic [2*NPASS-1:0]                          carrega,
    output logic                                        catraca,
    output logic [2:0]                                  conta,
    output logic [((NPASS > 1) ? $clog2(NPASS) : 1)-1:0] atual,
    output logic                                        negado
);

    localparam int AW = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam int TW = (T_LIBERA > 1) ? $clog2(T_LIBERA) : 1;
    localparam logic [3:0] SAT = 4'(SALDO_MAX);

    typedef enum logic {
        TRAVADA  = 1'b0,
        LIBERADA = 1'b1
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [2:0]       saldo_q [NPASS];
    logic [2:0]       saldo_d [NPASS];
    logic [NPASS-1:0] armado_q, armado_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [AW-1:0]    atual_q, atual_d;
    logic             negado_q, negado_d;

    logic [NPASS-1:0] req;
    logic [NPASS-1:0] servido;
    logic [NPASS-1:0] debito;
    logic             tem_vencedor;
    logic [AW-1:0]    venc;

    assign req = passe & armado_q;

`ifdef CATRACA_RR_EN
    logic [AW-1:0] prio_q, prio_d;
    int            soma;

    // First requester at or above prio, wrapping past NPASS-1.
    always_comb begin
        tem_vencedor = 1'b0;
        venc         = '0;
        soma         = 0;
        for (int k = 0; k < NPASS; k++) begin
            soma = int'(prio_q) + k;
            if (soma >= NPASS) begin
                soma = soma - NPASS;
            end
            if (!tem_vencedor && req[AW'(soma)]) begin
                tem_vencedor = 1'b1;
                venc         = AW'(soma);
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (|servido) begin
            prio_d = (venc == AW'(NPASS - 1)) ? '0 : venc + AW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    int n_req;

    // Without round-robin only a lone requester is served; contention stalls.
    always_comb begin
        n_req = 0;
        venc  = '0;
        for (int k = 0; k < NPASS; k++) begin
            if (req[k]) begin
                n_req = n_req + 1;
                venc  = AW'(k);
            end
        end
        tem_vencedor = (n_req == 1);
    end
`endif

    always_comb begin
        estado_d = estado_q;
        timer_d  = timer_q;
        atual_d  = atual_q;
        negado_d = 1'b0;
        servido  = '0;
        debito   = '0;
        case (estado_q)
            TRAVADA: begin
                if (tem_vencedor) begin
                    atual_d       = venc;
                    servido[venc] = 1'b1;
                    if (saldo_q[venc] != 3'd0) begin
                        debito[venc] = 1'b1;
                        timer_d      = TW'(T_LIBERA - 1);
                        estado_d     = LIBERADA;
                    end else begin
                        negado_d = 1'b1;
                    end
                end
            end
            LIBERADA: begin
                if (timer_q == '0) begin
                    estado_d = TRAVADA;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: estado_d = TRAVADA;
        endcase
    end

    // Top-up and debit both apply before saturation; 4 bits hold 7+3.
    always_comb begin
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NPASS; i++) begin
            n          = {1'b0, saldo_q[i]} + {2'b00, carrega[2*i +: 2]} - {3'b000, debito[i]};
            saldo_d[i] = (n > SAT) ? SAT[2:0] : n[2:0];
        end
    end

    // Releasing the card re-arms it; serving it disarms until the next release.
    always_comb begin
        for (int i = 0; i < NPASS; i++) begin
            if (!passe[i]) begin
                armado_d[i] = 1'b1;
            end else if (servido[i]) begin
                armado_d[i] = 1'b0;
            end else begin
                armado_d[i] = armado_q[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= TRAVADA;
            timer_q  <= '0;
            atual_q  <= '0;
            negado_q <= 1'b0;
            armado_q <= '0;
            for (int i = 0; i < NPASS; i++) begin
                saldo_q[i] <= 3'd0;
            end
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
            atual_q  <= atual_d;
            negado_q <= negado_d;
            armado_q <= armado_d;
            for (int i = 0; i < NPASS; i++) begin
                saldo_q[i] <= saldo_d[i];
            end
        end
    end

    assign catraca = (estado_q == LIBERADA);
    assign conta   = saldo_q[atual_q];
    assign atual   = atual_q;
    assign negado  = negado_q;

endmodule

// File: tb/tb_catraca_arbitro.sv
// tb/tb_catraca_arbitro.sv - self-checking bench for catraca_arbitro

module tb_catraca_arbitro;

    localparam int NPASS     = 2;
    localparam int SALDO_MAX = 5;
    localparam int T_LIBERA  = 3;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic [1:0] passe   = '0;
    logic [3:0] carrega = '0;
    wire        catraca;
    wire  [2:0] conta;
    wire  [0:0] atual;
    wire        negado;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    catraca_arbitro #(
        .NPASS    (NPASS),
        .SALDO_MAX(SALDO_MAX),
        .T_LIBERA (T_LIBERA)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .passe  (passe),
        .carrega(carrega),
        .catraca(catraca),
        .conta  (conta),
        .atual  (atual),
        .negado (negado)
    );

    always #5 clock = ~clock;

    // Reference: balances as integers, turnstile as a count of released cycles left.
    int m_saldo  [NPASS];
    bit m_armado [NPASS];
    bit m_req    [NPASS];
    int m_debit  [NPASS];
    int m_resto  = 0;
    int m_atual  = 0;
    bit m_negado = 1'b0;
    int m_g;
`ifdef CATRACA_RR_EN
    int m_prio = 0;
`else
    int m_nreq;
`endif

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPASS; i++) begin
                m_saldo[i]  = 0;
                m_armado[i] = 1'b0;
            end
            m_resto  = 0;
            m_atual  = 0;
            m_negado = 1'b0;
`ifdef CATRACA_RR_EN
            m_prio   = 0;
`endif
        end else begin
            m_g      = -1;
            m_negado = 1'b0;
            for (int i = 0; i < NPASS; i++) begin
                m_debit[i] = 0;
                m_req[i]   = passe[i] && m_armado[i];
            end
            if (m_resto > 0) begin
                m_resto = m_resto - 1;
            end else begin
`ifdef CATRACA_RR_EN
                for (int k = 0; k < NPASS; k++) begin
                    if (m_g < 0 && m_req[(m_prio + k) % NPASS]) m_g = (m_prio + k) % NPASS;
                end
`else
                m_nreq = 0;
                for (int i = 0; i < NPASS; i++) begin
                    if (m_req[i]) begin
                        m_nreq = m_nreq + 1;
                        m_g    = i;
                    end
                end
                if (m_nreq != 1) m_g = -1;
`endif
                if (m_g >= 0) begin
                    m_atual = m_g;
                    if (m_saldo[m_g] > 0) begin
                        m_debit[m_g] = 1;
                        m_resto      = T_LIBERA;
                    end else begin
                        m_negado = 1'b1;
                    end
`ifdef CATRACA_RR_EN
                    m_prio = (m_g + 1) % NPASS;
`endif
                end
            end
            for (int i = 0; i < NPASS; i++) begin
                m_saldo[i] = m_saldo[i] + int'(carrega[2*i +: 2]) - m_debit[i];
                if (m_saldo[i] > SALDO_MAX) m_saldo[i] = SALDO_MAX;
                if (!passe[i]) m_armado[i] = 1'b1;
                else if (i == m_g) m_armado[i] = 1'b0;
            end
        end
    end

    task automatic chk(input string nome, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_on) begin
            chk("catraca", int'(catraca), (m_resto > 0) ? 1 : 0);
            chk("negado", int'(negado), int'(m_negado));
            chk("atual", int'(atual), m_atual);
            chk("conta", int'(conta), m_saldo[m_atual]);
        end
    end

    // One sampling edge with the given inputs; returns 2 time units after it.
    task automatic aplica(input logic [1:0] p, input logic [3:0] c);
        @(negedge clock);
        #1;
        passe   = p;
        carrega = c;
        @(posedge clock);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        repeat (3) @(posedge clock);
        cmp_on = 1'b1;
        @(negedge clock);
        #1;
        reset = 1'b0;
        chk("rst_catraca", int'(catraca), 0);
        chk("rst_conta", int'(conta), 0);
        chk("rst_atual", int'(atual), 0);
        chk("rst_negado", int'(negado), 0);

        aplica(2'b00, 4'b0000);
        aplica(2'b00, 4'b1100);
        aplica(2'b10, 4'b0000);
        chk("t1_catraca", int'(catraca), 1);
        chk("t1_conta", int'(conta), 2);
        chk("t1_atual", int'(atual), 1);
        cnt = 1;
        repeat (8) begin
            @(posedge clock);
            #2;
            if (catraca) cnt++;
        end
        chk("t1_largura", cnt, 3);
        chk("t1_preso", int'(conta), 2);

        aplica(2'b00, 4'b0000);
        aplica(2'b01, 4'b0000);
        chk("neg_pulso", int'(negado), 1);
        chk("neg_catraca", int'(catraca), 0);
        chk("neg_atual", int'(atual), 0);
        aplica(2'b01, 4'b0000);
        chk("neg_unico", int'(negado), 0);

        aplica(2'b00, 4'b0011);
        aplica(2'b00, 4'b0011);
        aplica(2'b00, 4'b0000);
        chk("sat_conta", int'(conta), 5);
        aplica(2'b01, 4'b0010);
        chk("sat_catraca", int'(catraca), 1);
        chk("sat_conta2", int'(conta), 5);
        repeat (5) aplica(2'b00, 4'b0000);

        aplica(2'b11, 4'b0000);
`ifdef CATRACA_RR_EN
        chk("rr_atual1", int'(atual), 1);
        chk("rr_conta1", int'(conta), 1);
        repeat (3) aplica(2'b11, 4'b0000);
        aplica(2'b11, 4'b0000);
        chk("rr_atual2", int'(atual), 0);
        chk("rr_catraca2", int'(catraca), 1);
        chk("rr_conta2", int'(conta), 4);
`else
        chk("norr_catraca1", int'(catraca), 0);
        repeat (4) aplica(2'b11, 4'b0000);
        chk("norr_catraca2", int'(catraca), 0);
        chk("norr_conta", int'(conta), 5);
`endif
        repeat (5) aplica(2'b00, 4'b0000);

        aplica(2'b01, 4'b0000);
        chk("lib_grant", int'(catraca), 1);
        aplica(2'b11, 4'b0000);
        aplica(2'b01, 4'b0000);
        aplica(2'b01, 4'b0000);
        aplica(2'b01, 4'b0000);
        chk("lib_solto_cat", int'(catraca), 0);
        chk("lib_solto_atual", int'(atual), 0);

        repeat (2) aplica(2'b00, 4'b0000);
        aplica(2'b01, 4'b0000);
        aplica(2'b11, 4'b0000);
        aplica(2'b11, 4'b0000);
        aplica(2'b11, 4'b0000);
        aplica(2'b11, 4'b0000);
        chk("lib_preso_atual", int'(atual), 1);
        chk("lib_preso_cat", int'(catraca), 1);

        #1;
        reset = 1'b1;
        #1;
        chk("arst_catraca", int'(catraca), 0);
        chk("arst_conta", int'(conta), 0);
        @(negedge clock);
        #1;
        reset = 1'b0;

        for (int n = 0; n < 800; n++) begin
            @(negedge clock);
            #1;
            for (int i = 0; i < NPASS; i++) begin
                if ($urandom_range(0, 3) == 0) passe[i] = ~passe[i];
                carrega[2*i +: 2] = ($urandom_range(0, 7) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
            end
        end
        aplica(2'b00, 4'b0000);
        repeat (4) @(posedge clock);
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
